// File: rtl/fib_responder.sv
// Iterative Fibonacci responder: fib(n) for signed n, with negative n clamped to 0 and silent wrap on overflow.
// Latency: n+1 clocks from the sampling edge to fib_valid for n>=0, and 1 clock for n<=0.
// Backpressure: the result is held in DONE until fib_accept; fib_ready is ignored outside IDLE.
module fib_responder #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fib_ready,
    input  logic [DATA_W-1:0] fib_in_n,
    output logic              fib_valid,
    input  logic              fib_accept,
    output logic [DATA_W-1:0] fib_out_0
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] n_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] i_q;
    logic              calc_done;

    // Signed compare clamps every n<=0 to a single pass through CALC.
    assign calc_done = $signed(i_q) >= $signed(n_q);
    assign fib_valid = (state == DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (fib_ready)  state_nxt = CALC;
            CALC:    if (calc_done)  state_nxt = DONE;
            DONE:    if (fib_accept) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            n_q       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            i_q       <= '0;
            fib_out_0 <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (fib_ready) begin
                        n_q <= fib_in_n;
                        a_q <= '0;
                        b_q <= {{(DATA_W-1){1'b0}}, 1'b1};
                        i_q <= '0;
                    end
                end
                CALC: begin
                    if (calc_done) begin
                        fib_out_0 <= a_q;
                    end else begin
                        a_q <= b_q;
                        b_q <= a_q + b_q;
                        i_q <= i_q + {{(DATA_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fib_responder.sv
// Directed bench for fib_responder: known results, latency, hold, overflow, abort and strobe collisions.
module tb_fib_responder;

    localparam int DATA_W = 32;

    logic              clk;
    logic              rst;
    logic              fib_ready;
    logic [DATA_W-1:0] fib_in_n;
    logic              fib_valid;
    logic              fib_accept;
    logic [DATA_W-1:0] fib_out_0;

    int total;
    int bad;

    fib_responder #(.DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .fib_ready  (fib_ready),
        .fib_in_n   (fib_in_n),
        .fib_valid  (fib_valid),
        .fib_accept (fib_accept),
        .fib_out_0  (fib_out_0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint obs, input longint exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Issue a call and wait for the result; inputs change and outputs are sampled on falling edges.
    task automatic start_and_wait(input int n, input longint exp_res, input int exp_lat);
        int cnt;
        @(negedge clk);
        fib_ready = 1'b1;
        fib_in_n  = n;
        @(negedge clk);
        fib_ready = 1'b0;
        fib_in_n  = $urandom;
        chk("valid_low_after_sample", longint'(fib_valid), 0);
        cnt = 0;
        while (fib_valid !== 1'b1 && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        chk($sformatf("latency_n%0d", n), cnt, exp_lat);
        chk($sformatf("result_n%0d", n), longint'($signed(fib_out_0)), exp_res);
    endtask

    task automatic accept_result(input longint exp_res);
        fib_accept = 1'b1;
        @(negedge clk);
        fib_accept = 1'b0;
        chk("valid_drop_on_accept", longint'(fib_valid), 0);
        chk("result_held_after_accept", longint'($signed(fib_out_0)), exp_res);
    endtask

    task automatic full_call(input int n, input longint exp_res, input int exp_lat);
        start_and_wait(n, exp_res, exp_lat);
        accept_result(exp_res);
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        rst        = 1'b0;
        fib_ready  = 1'b0;
        fib_accept = 1'b0;
        fib_in_n   = '0;

        #12;
        chk("reset_valid", longint'(fib_valid), 0);
        chk("reset_out", longint'(fib_out_0), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("post_reset_valid", longint'(fib_valid), 0);

        full_call(0, 0, 1);
        full_call(1, 1, 2);
        full_call(2, 1, 3);
        full_call(3, 2, 4);
        full_call(8, 21, 9);
        full_call(-5, 0, 1);
        full_call(47, -64'sd1323752223, 48);

        // Result is held while the caller stalls and keeps strobing fib_ready.
        start_and_wait(8, 21, 9);
        for (int k = 0; k < 20; k++) begin
            fib_ready = (k % 2 == 0) && (k < 19);
            fib_in_n  = k + 3;
            @(negedge clk);
            chk("held_valid", longint'(fib_valid), 1);
            chk("held_out", longint'($signed(fib_out_0)), 21);
        end
        fib_ready = 1'b0;
        accept_result(21);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("no_ghost_after_hold", longint'(fib_valid), 0);
        end

        // Asynchronous abort in the middle of a computation.
        @(negedge clk);
        fib_ready = 1'b1;
        fib_in_n  = 8;
        @(negedge clk);
        fib_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_valid", longint'(fib_valid), 0);
        chk("abort_out", longint'(fib_out_0), 0);
        @(negedge clk);
        rst = 1'b1;
        full_call(3, 2, 4);

        // fib_ready colliding with fib_accept in DONE must not start a call.
        start_and_wait(2, 1, 3);
        fib_ready  = 1'b1;
        fib_accept = 1'b1;
        fib_in_n   = 5;
        @(negedge clk);
        fib_ready  = 1'b0;
        fib_accept = 1'b0;
        chk("collide_valid_drop", longint'(fib_valid), 0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("collide_no_call", longint'(fib_valid), 0);
        end
        chk("collide_out_held", longint'($signed(fib_out_0)), 1);

        full_call(8, 21, 9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
